// File: rtl/vga_pkg.sv
// Shared text-mode definitions: character codes, screen geometry defaults and
// the writer state encoding, common to the UART text writer and the char-gen.
package vga_pkg;

  localparam int unsigned DEF_COLS   = 80;
  localparam int unsigned DEF_ROWS   = 30;
  localparam int unsigned DEF_ADDR_W = 12;

  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned CHR_W = 8;

  localparam logic [CHR_W-1:0] CHR_BS    = 8'h08;
  localparam logic [CHR_W-1:0] CHR_LF    = 8'h0A;
  localparam logic [CHR_W-1:0] CHR_FF    = 8'h0C;
  localparam logic [CHR_W-1:0] CHR_CR    = 8'h0D;
  localparam logic [CHR_W-1:0] CHR_SPACE = 8'h20;
  localparam logic [CHR_W-1:0] CHR_TILDE = 8'h7E;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  // Glyph range the char-gen can render.
  function automatic logic is_printable(input logic [CHR_W-1:0] c);
    return (c >= CHR_SPACE) && (c <= CHR_TILDE);
  endfunction

endpackage

// File: rtl/uart_text_writer_if.sv
// Byte stream from uart_rx in, text RAM write port out.
// master = the text writer, slave = its environment (receiver + RAM).
interface uart_text_writer_if #(
  parameter int unsigned ADDR_W = 12
);

  logic [7:0]        rx_data;
  logic              rx_send;
  logic              rx_fe;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  rx_data, rx_send, rx_fe,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_data, rx_send, rx_fe,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/text_cursor.sv
// Text cursor: col/row registers with all wrap rules, plus the linear
// text RAM address of the current cell.
module text_cursor
  import vga_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock100,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              cr,
  input  logic              lf,
  input  logic              home,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr_c
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] row_d;
  logic [ROW_W-1:0] row_next;

  // Row below the current one; bottom row wraps to the top (no scrolling).
  assign row_next = (row == ROW_LAST) ? '0 : row + ROW_W'(1);

  always_comb begin
    col_d = col;
    row_d = row;
    if (home) begin
      col_d = '0;
      row_d = '0;
    end else if (inc) begin
      if (col == COL_LAST) begin
        col_d = '0;
        row_d = row_next;
      end else begin
        col_d = col + COL_W'(1);
      end
    end else if (dec) begin
      if (col != '0) begin
        col_d = col - COL_W'(1);
      end
    end else if (cr) begin
      col_d = '0;
    end else if (lf) begin
      row_d = row_next;
    end
  end

  always_ff @(posedge clock100) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_d;
      row <= row_d;
    end
  end

  assign addr_c = ADDR_W'(32'(row) * COLS + 32'(col));

endmodule

// File: rtl/uart_text_writer.sv
// Turns the uart_rx byte stream into char-gen text RAM writes: printable
// bytes, CR/LF/BS cursor control and an FF full-screen clear sweep.
module uart_text_writer
  import vga_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic               clock100,
  input  logic               reset,
  uart_text_writer_if.master bus,
  output logic [COL_W-1:0]   cursor_col,
  output logic [ROW_W-1:0]   cursor_row,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         fe_cnt
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned CLR_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              busy_d;
  logic              overrun_d;
  logic [7:0]        fe_cnt_d;

  logic              cur_inc, cur_dec, cur_cr, cur_lf, cur_home;
  logic [ADDR_W-1:0] cur_addr;

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clock100 (clock100),
    .reset    (reset),
    .inc      (cur_inc),
    .dec      (cur_dec),
    .cr       (cur_cr),
    .lf       (cur_lf),
    .home     (cur_home),
    .col      (cursor_col),
    .row      (cursor_row),
    .addr_c   (cur_addr)
  );

  // Decode, clear sweep and error bookkeeping; every result lands in a register.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = bus.wr_addr;
    wr_data_d = bus.wr_data;
    busy_d    = busy;
    overrun_d = overrun;
    fe_cnt_d  = fe_cnt;
    cur_inc   = 1'b0;
    cur_dec   = 1'b0;
    cur_cr    = 1'b0;
    cur_lf    = 1'b0;
    cur_home  = 1'b0;

    if (bus.rx_send && bus.rx_fe && (fe_cnt != 8'hFF)) begin
      fe_cnt_d = fe_cnt + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.rx_send && !bus.rx_fe) begin
          if (is_printable(bus.rx_data)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = bus.rx_data;
            cur_inc   = 1'b1;
          end else begin
            case (bus.rx_data)
              CHR_CR: cur_cr = 1'b1;
              CHR_LF: cur_lf = 1'b1;
              CHR_BS: begin
                if (cursor_col != '0) begin
                  cur_dec   = 1'b1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = cur_addr - ADDR_W'(1);
                  wr_data_d = CHR_SPACE;
                end
              end
              CHR_FF: begin
                // First sweep write (address 0) goes out together with busy.
                state_d   = CLEAR;
                busy_d    = 1'b1;
                cur_home  = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = CHR_SPACE;
                clr_d     = CLR_W'(1);
              end
              default: ;
            endcase
          end
        end
      end

      CLEAR: begin
        if (bus.rx_send) begin
          overrun_d = 1'b1;
        end
        if (clr_q == CLR_W'(CELLS)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(clr_q);
          wr_data_d = CHR_SPACE;
          clr_d     = clr_q + CLR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock100) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_q       <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      fe_cnt      <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      bus.wr_en   <= wr_en_d;
      bus.wr_addr <= wr_addr_d;
      bus.wr_data <= wr_data_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      fe_cnt      <= fe_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_text_writer.sv
// Bench for uart_text_writer: linear-position screen model with a queue of
// pending clear writes, checked every cycle, plus directed literal checks.
module tb_uart_text_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;

  logic       clock100 = 1'b0;
  logic       reset    = 1'b1;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;
  logic       overrun;
  logic [7:0] fe_cnt;

  uart_text_writer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_text_writer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock100   (clock100),
    .reset      (reset),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .overrun    (overrun),
    .fe_cnt     (fe_cnt)
  );

  always #5 clock100 = ~clock100;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic cmp(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Model: cursor as linear screen position, clear sweep as a queue of addresses.
  int m_col, m_row, m_fe, m_addr, m_data;
  bit m_wr_en, m_busy, m_ovr;
  int clr_q[$];

  always @(posedge clock100) begin
    int b;
    int p;
    if (reset) begin
      m_col = 0; m_row = 0; m_fe = 0; m_addr = 0; m_data = 0;
      m_wr_en = 0; m_busy = 0; m_ovr = 0;
      clr_q.delete();
    end else begin
      m_wr_en = 0;
      if (bus.rx_send && bus.rx_fe && m_fe < 255) m_fe = m_fe + 1;
      if (m_busy) begin
        if (bus.rx_send) m_ovr = 1;
        if (clr_q.size() > 0) begin
          m_wr_en = 1; m_addr = clr_q.pop_front(); m_data = 32;
        end else begin
          m_busy = 0;
        end
      end else if (bus.rx_send && !bus.rx_fe) begin
        b = int'(bus.rx_data);
        p = m_row * COLS + m_col;
        if (b >= 32 && b <= 126) begin
          m_wr_en = 1; m_addr = p; m_data = b;
          p = (p + 1) % CELLS;
          m_col = p % COLS; m_row = p / COLS;
        end else if (b == 13) begin
          m_col = 0;
        end else if (b == 10) begin
          m_row = (m_row + 1) % ROWS;
        end else if (b == 8) begin
          if (m_col > 0) begin
            m_col = m_col - 1; m_wr_en = 1; m_addr = p - 1; m_data = 32;
          end
        end else if (b == 12) begin
          m_busy = 1; m_col = 0; m_row = 0;
          m_wr_en = 1; m_addr = 0; m_data = 32;
          clr_q.delete();
          for (int i = 1; i < CELLS; i++) clr_q.push_back(i);
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clock100) begin
    if (checking) begin
      cmp("wr_en", int'(bus.wr_en), int'(m_wr_en));
      if (m_wr_en) begin
        cmp("wr_addr", int'(bus.wr_addr), m_addr);
        cmp("wr_data", int'(bus.wr_data), m_data);
      end
      cmp("cursor_col", int'(cursor_col), m_col);
      cmp("cursor_row", int'(cursor_row), m_row);
      cmp("busy", int'(busy), int'(m_busy));
      cmp("overrun", int'(overrun), int'(m_ovr));
      cmp("fe_cnt", int'(fe_cnt), m_fe);
    end
  end

  task automatic do_reset();
    bus.rx_send = 1'b0; bus.rx_fe = 1'b0; bus.rx_data = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clock100);
    #1 reset = 1'b0;
  endtask

  // One-cycle strobe; returns 1ns after the edge that registers the result.
  task automatic send(input logic [7:0] d, input logic fe);
    bus.rx_data = d; bus.rx_fe = fe; bus.rx_send = 1'b1;
    @(posedge clock100);
    #1 bus.rx_send = 1'b0; bus.rx_fe = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] d, input logic fe);
    send(d, fe);
    @(posedge clock100);
    #1;
  endtask

  initial begin
    int n;
    int r;
    int ff_budget;
    bit prev_send;

    do_reset();
    checking = 1'b1;
    @(negedge clock100);
    cmp("rst_wr_en", int'(bus.wr_en), 0);
    cmp("rst_wr_addr", int'(bus.wr_addr), 0);
    cmp("rst_wr_data", int'(bus.wr_data), 0);
    cmp("rst_col", int'(cursor_col), 0);
    cmp("rst_row", int'(cursor_row), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_fe", int'(fe_cnt), 0);

    // '@' lands at address 0
    send(8'h40, 1'b0);
    @(negedge clock100);
    cmp("at_wr_en", int'(bus.wr_en), 1);
    cmp("at_addr", int'(bus.wr_addr), 0);
    cmp("at_data", int'(bus.wr_data), 64);
    cmp("at_col", int'(cursor_col), 1);

    // 80 x 'A' then 'B' wraps to row 1
    do_reset();
    for (int i = 0; i < 80; i++) send_gap(8'h41, 1'b0);
    send(8'h42, 1'b0);
    @(negedge clock100);
    cmp("b_addr", int'(bus.wr_addr), 80);
    cmp("b_col", int'(cursor_col), 1);
    cmp("b_row", int'(cursor_row), 1);

    // bottom-right cell, then wrap to (0,0)
    do_reset();
    for (int i = 0; i < 29; i++) send_gap(8'h0A, 1'b0);
    for (int i = 0; i < 79; i++) send_gap(8'h41, 1'b0);
    send(8'h5A, 1'b0);
    @(negedge clock100);
    cmp("z_addr", int'(bus.wr_addr), 2399);
    cmp("z_col", int'(cursor_col), 0);
    cmp("z_row", int'(cursor_row), 0);

    // "AB", BS, CR, LF
    do_reset();
    send_gap(8'h41, 1'b0);
    send_gap(8'h42, 1'b0);
    send(8'h08, 1'b0);
    @(negedge clock100);
    cmp("bs_wr_en", int'(bus.wr_en), 1);
    cmp("bs_addr", int'(bus.wr_addr), 1);
    cmp("bs_data", int'(bus.wr_data), 32);
    cmp("bs_col", int'(cursor_col), 1);
    send(8'h0D, 1'b0);
    @(negedge clock100);
    cmp("cr_wr_en", int'(bus.wr_en), 0);
    cmp("cr_col", int'(cursor_col), 0);
    send(8'h0A, 1'b0);
    @(negedge clock100);
    cmp("lf_wr_en", int'(bus.wr_en), 0);
    cmp("lf_col", int'(cursor_col), 0);
    cmp("lf_row", int'(cursor_row), 1);
    send(8'h08, 1'b0);
    @(negedge clock100);
    cmp("bs0_wr_en", int'(bus.wr_en), 0);
    cmp("bs0_row", int'(cursor_row), 1);

    // framing errors, saturating count
    do_reset();
    send(8'h41, 1'b1);
    @(negedge clock100);
    cmp("fe_wr_en", int'(bus.wr_en), 0);
    cmp("fe_cnt1", int'(fe_cnt), 1);
    cmp("fe_col", int'(cursor_col), 0);
    for (int i = 0; i < 299; i++) send_gap(8'h41, 1'b1);
    @(negedge clock100);
    cmp("fe_cnt255", int'(fe_cnt), 255);

    // full clear sweep with a byte dropped mid-sweep
    do_reset();
    send_gap(8'h41, 1'b0);
    send(8'h0C, 1'b0);
    @(negedge clock100);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      bus.rx_data = 8'h51;
      bus.rx_send = (n == 500);
      @(negedge clock100);
    end
    bus.rx_send = 1'b0;
    cmp("busy_cycles", n, 2400);
    cmp("ff_overrun", int'(overrun), 1);
    cmp("ff_col", int'(cursor_col), 0);
    cmp("ff_row", int'(cursor_row), 0);
    cmp("ff_wr_en", int'(bus.wr_en), 0);

    // reset 100 cycles into a sweep
    do_reset();
    send(8'h0C, 1'b0);
    repeat (100) @(negedge clock100);
    reset = 1'b1;
    @(posedge clock100);
    #1 reset = 1'b0;
    @(negedge clock100);
    cmp("rmid_busy", int'(busy), 0);
    cmp("rmid_wr_en", int'(bus.wr_en), 0);
    send(8'h58, 1'b0);
    @(negedge clock100);
    cmp("rmid_x_en", int'(bus.wr_en), 1);
    cmp("rmid_x_addr", int'(bus.wr_addr), 0);
    cmp("rmid_x_data", int'(bus.wr_data), 88);

    // randomized traffic, no back-to-back strobes
    do_reset();
    ff_budget = 2;
    prev_send = 1'b0;
    for (int c = 0; c < 7000; c++) begin
      @(posedge clock100);
      #1;
      bus.rx_fe = 1'b0;
      bus.rx_send = !prev_send && ($urandom_range(0, 99) < 45);
      prev_send = bus.rx_send;
      r = int'($urandom_range(0, 99));
      if (r < 55)      bus.rx_data = 8'($urandom_range(32, 126));
      else if (r < 64) bus.rx_data = 8'h0D;
      else if (r < 72) bus.rx_data = 8'h0A;
      else if (r < 82) bus.rx_data = 8'h08;
      else if (r < 89) begin bus.rx_data = 8'($urandom_range(0, 255)); bus.rx_fe = 1'b1; end
      else if (r < 98) bus.rx_data = 8'($urandom_range(0, 255));
      else if (ff_budget > 0 && bus.rx_send) begin bus.rx_data = 8'h0C; ff_budget--; end
      else bus.rx_data = 8'h7F;
    end
    @(posedge clock100);
    #1 bus.rx_send = 1'b0; bus.rx_fe = 1'b0;
    repeat (4) @(posedge clock100);
    @(negedge clock100);
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_text_writer.md
Name: uart_text_writer

Overview:
- Sequences the uart_rx byte stream into the VGA character buffer.
- Consumes received bytes (data/send/fe from uart_rx), keeps a text cursor, and handles control codes CR, LF, BS and FF (clear screen).
- Issues single-cycle write strobes to the char-gen text RAM.
- Sits between uart_rx and the char-gen RAM write port; runs on the 100 MHz system clock.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, text RAM address width; must satisfy COLS*ROWS <= 2**ADDR_W

Ports:
- clock100  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from uart_rx
- rx_send  in  1  one-cycle strobe; rx_data valid
- rx_fe  in  1  framing error, qualified by rx_send
- wr_en  out  1  text RAM write strobe, one cycle
- wr_addr  out  ADDR_W  text RAM address = row*COLS + col
- wr_data  out  8  character code to write
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- busy  out  1  high while a clear-screen sweep runs
- overrun  out  1  sticky; set when a byte is dropped during busy
- fe_cnt  out  8  framing-error count, saturates at 255

Behaviour:
- Clock and reset: one clock (clock100). Reset is synchronous, active-high, and wins over every other event in the same cycle.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cursor_col=0, cursor_row=0, busy=0, overrun=0, fe_cnt=0, state=IDLE.
- States: IDLE, CLEAR.
- IDLE, rx_send=1 in cycle N, decoded on rx_data; all results registered, visible in N+1:
  - rx_fe=1 (regardless of data): byte discarded, fe_cnt+1 (saturating), no write, cursor unchanged. fe has priority over data.
  - 0x20..0x7E printable: wr_en=1, wr_addr=row*COLS+col using the pre-update cursor, wr_data=byte. Cursor advances:
    - col+1;
    - if col was COLS-1: col=0, row+1;
    - if row was ROWS-1 as well: row=0 (wrap, no scroll).
  - 0x0D CR: col=0, no write.
  - 0x0A LF: row+1, wrapping ROWS-1 -> 0; col kept; no write.
  - 0x08 BS: if col>0, col-1 and write 0x20 at the new position. If col=0: no change, no write (no reverse row wrap).
  - 0x0C FF: enter CLEAR in N+1, busy=1; cursor set to (0,0) in N+1.
  - Any other byte (0x00..0x1F not listed above, or 0x7F..0xFF): ignored, no write.
- rx_send=0: wr_en=0 in the next cycle. wr_en is never high for two consecutive cycles from IDLE.
- CLEAR:
  - One write per cycle: wr_en=1, wr_data=0x20, wr_addr counts 0..COLS*ROWS-1. First write is in cycle N+1, so 2400 cycles at defaults.
  - After the last address: wr_en=0, busy=0, return to IDLE. Exact timing: last write in cycle N+COLS*ROWS, busy falls in N+COLS*ROWS+1.
  - rx_send during CLEAR: byte dropped, overrun set (sticky until reset). If rx_fe=1 at the same time, fe_cnt also increments.
- Reset mid-CLEAR: sweep aborts immediately, state=IDLE, all outputs return to reset values. Partially cleared RAM is left as is.
- Arithmetic:
  - wr_addr is computed from registered col/row with a constant multiply, truncated to ADDR_W.
  - col and row counters never hold values >= COLS or >= ROWS.

Decomposition:
- Shared package (vga_pkg): character constants CHR_BS=0x08, CHR_LF=0x0A, CHR_FF=0x0C, CHR_CR=0x0D, CHR_SPACE=0x20; state enum {IDLE, CLEAR}; defaults COLS/ROWS, shared with the char-gen.
- One sub-module: text_cursor.
  - Holds the col/row registers.
  - Accepts inc/dec/cr/lf/home commands and produces the linear address.
  - Contains all wrap logic.
- FSM, decoder, clear counter and error counters stay in uart_text_writer.

Test Plan:
- Byte 0x40 '@' after reset: next cycle wr_en=1, wr_addr=0, wr_data=0x40; cursor becomes (1,0).
- 80 bytes of 'A' then 'B': the 'B' write has wr_addr=80; cursor ends at (1,1). Cursor preset to (79,29), then 'Z': wr_addr=2399, cursor wraps to (0,0).
- Sequence "AB", 0x08, 0x0D, 0x0A:
  - BS writes 0x20 at addr 1, cursor (1,0);
  - CR gives (0,0);
  - LF gives (0,1);
  - no writes for CR/LF.
- rx_send with rx_fe=1, data 0x41: no write, fe_cnt=1. 300 such errors: fe_cnt=255.
- 0x0C:
  - busy high for exactly 2400 cycles with wr_addr 0..2399 and wr_data=0x20;
  - byte sent mid-sweep is dropped and sets overrun=1;
  - cursor reads (0,0) after the sweep.
- reset asserted 100 cycles into a sweep: next cycle busy=0, wr_en=0, state IDLE. A following 'X' writes to addr 0.
